if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Captures each fetched instruction word together with its PC+1 value, buffers up to DEPTH entries, and presents them in order to decode over a valid/ready handshake.
- Discards every buffered entry on a redirect (branch/jump resolved), so wrong-path instructions never reach decode.
- Its in_ready output backpressures fetch: fetch halt = ~in_ready.

Parameters:
- DEPTH, 2: number of entries; must be a power of two and at least 2.
- WIDTH, 16: instruction and PC width in bits.
- NOP, 16'h0000: instruction value driven on out_instr when out_valid is 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low: rst = 0 resets immediately, independent of clk.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_instr  input  WIDTH  fetched instruction word.
- in_pc  input  WIDTH  PC+1 of the fetched instruction.
- in_ready  output  1  queue accepts a push this cycle.
- flush  input  1  redirect; kill all queued and incoming entries.
- out_valid  output  1  head entry valid.
- out_instr  output  WIDTH  head instruction, or NOP when not valid.
- out_pc  output  WIDTH  head PC+1, or 0 when not valid.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst = 0, asynchronous):
  - write pointer, read pointer and count go to 0.
  - out_valid = 0, out_instr = NOP, out_pc = 0, in_ready = 1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately.
- Push: occurs when in_valid & in_ready & ~flush. The entry is written at the write pointer, which then increments modulo DEPTH.
- Pop: occurs when out_valid & out_ready & ~flush. The read pointer increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- in_ready = (count < DEPTH).
  - Depends on registered state only; there is no combinational path from out_ready.
  - When full, a same-cycle pop does not enable a push.
- Outputs:
  - out_valid = (count != 0).
  - out_instr and out_pc are read from storage at the read pointer, so they are stable whenever out_valid is 1.
  - While out_valid is 0, out_instr = NOP and out_pc = 0.
- Latency: a push at cycle N appears on the outputs at cycle N+1 when the queue was empty. There is no in-to-out combinational path.
- Flush:
  - Highest priority. The next state is pointers = 0 and count = 0, so out_valid = 0 on the following cycle.
  - A push or pop in the flush cycle is ignored. An in_valid instruction in that cycle is dropped.
  - in_ready is not gated by flush.
- Ordering: strict FIFO. Pointer wrap-around is transparent to the consumer.
- Illegal cases: count never exceeds DEPTH and never underflows. The bench checks both with assertions.

Decomposition:
- Shared cpu package holds:
  - INSTR_W = 16.
  - NOP_INSTR = 16'h0000.
  - the clog2-based count-width helper.
- One sub-module, if_id_storage: a DEPTH x (2*WIDTH) register array with a synchronous write port and an asynchronous read port.
- Pointer, count and flush control stay in if_id_queue.

Test Plan:
- Reset: hold rst = 0 for 3 cycles while driving in_valid = 1. Expect out_valid = 0, out_instr = 16'h0000, count = 0, in_ready = 1 throughout.
- Single pass:
  - Stimulus: push instr 16'h1234 with pc 16'h0001 in cycle N; out_ready = 0.
  - Cycle N+1: out_valid = 1, out_instr = 16'h1234, out_pc = 16'h0001, count = 1.
  - Assert out_ready: out_valid = 0 next cycle.
- Fill and backpressure:
  - Stimulus: DEPTH = 2, out_ready = 0, push A1 then A2.
  - Expect count = 2 and in_ready = 0; a third in_valid (A3) is not accepted.
  - Assert out_ready: A1 then A2 appear in order.
- Flush:
  - Stimulus: two entries queued; assert flush together with in_valid = 1 (instr 16'hBEEF) and out_ready = 1.
  - Next cycle: count = 0, out_valid = 0; 16'hBEEF never appears on out_instr.
- Streaming wrap-around:
  - Stimulus: 10 back-to-back pushes (instr = 16'h0100 + i), with out_ready = 1 continuously.
  - Expect all 10 values in order, each one cycle after its push; count stays at most 1 and the pointers wrap without loss.
- Asynchronous reset mid-stream: drop rst between clock edges while count = 2. Expect out_valid = 0 immediately, before the next rising edge of clk.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared widths, NOP encoding and count-width helper for the fetch/decode queue
package if_id_queue_pkg;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch push side, decode pop side, flush and occupancy of the instruction queue
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INSTR_W
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [cnt_w(DEPTH)-1:0] count;
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count
  );
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/if_id_storage.sv
// if_id_storage: DEPTH-entry register array, synchronous write, asynchronous read
module if_id_storage #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  // write the pushed entry; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order instruction buffer between fetch and decode with redirect flush
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = INSTR_W,
  parameter logic [WIDTH-1:0] NOP = NOP_INSTR
) (
  input logic clk,
  input logic rst,
  if_id_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  logic [2*WIDTH-1:0] rd_data;
  assign q.in_ready = count_q < CW'(DEPTH);
  assign q.out_valid = count_q != '0;
  assign q.count = count_q;
  assign push = q.in_valid & q.in_ready & ~q.flush;
  assign pop = q.out_valid & q.out_ready & ~q.flush;
  // flush returns to empty; otherwise pointers advance on their handshakes and wrap at DEPTH
  always_comb begin
    wr_ptr_d = q.flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = q.flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = q.flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // reset drops every entry at once, independent of clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  if_id_storage #(.DEPTH(DEPTH), .W(2*WIDTH), .AW(AW)) u_storage (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata({q.in_instr, q.in_pc}),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );
  assign q.out_instr = q.out_valid ? rd_data[2*WIDTH-1:WIDTH] : NOP;
  assign q.out_pc = q.out_valid ? rd_data[WIDTH-1:0] : '0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: scoreboard bench for if_id_queue with directed vectors
module tb_if_id_queue;
  import if_id_queue_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst = 0;
  logic mon_en = 0;
  int errors = 0;
  int checks = 0;
  int mcnt = 0;
  logic [31:0] exp_q[$];
  if_id_queue_if #(.DEPTH(DEPTH), .WIDTH(16)) q();
  if_id_queue #(.DEPTH(DEPTH), .WIDTH(16), .NOP(16'h0000)) dut (.clk(clk), .rst(rst), .q(q));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic iv, input logic [15:0] ins, input logic [15:0] pc, input logic ordy, input logic fl);
    logic pushed, popped;
    q.in_valid = iv;
    q.in_instr = ins;
    q.in_pc = pc;
    q.out_ready = ordy;
    q.flush = fl;
    @(posedge clk);
    pushed = iv && mcnt < DEPTH && !fl;
    popped = mcnt != 0 && ordy && !fl;
    if (fl) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      if (pushed) exp_q.push_back({ins, pc});
      mcnt = mcnt + int'(pushed) - int'(popped);
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (rst && mon_en) begin
      chk("count", 32'(q.count), 32'(mcnt));
      chk("in_ready", 32'(q.in_ready), 32'(mcnt < DEPTH));
      chk("out_valid", 32'(q.out_valid), 32'(mcnt != 0));
      assert (q.count <= DEPTH) else begin
        errors++;
        $display("FAIL count_bound: got %0d limit %0d", q.count, DEPTH);
      end
      if (q.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_head", {q.out_instr, q.out_pc}, 32'hxxxx_xxxx);
        else chk("head", {q.out_instr, q.out_pc}, exp_q[0]);
        if (q.out_ready && !q.flush && exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        chk("idle_out", {q.out_instr, q.out_pc}, 32'h0000_0000);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    q.in_valid = 1;
    q.in_instr = 16'hdead;
    q.in_pc = 16'h0007;
    q.out_ready = 0;
    q.flush = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(q.out_valid), 0);
      chk("rst_out_instr", 32'(q.out_instr), 0);
      chk("rst_count", 32'(q.count), 0);
      chk("rst_in_ready", 32'(q.in_ready), 1);
    end
    @(posedge clk);
    #1;
    q.in_valid = 0;
    rst = 1;
    mon_en = 1;
    step(1, 16'h1234, 16'h0001, 0, 0);
    step(0, 16'h0000, 16'h0000, 0, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h0000, 16'h0000, 0, 0);
    step(1, 16'haa01, 16'h0011, 0, 0);
    step(1, 16'haa02, 16'h0012, 0, 0);
    step(1, 16'haa03, 16'h0013, 0, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h0000, 16'h0000, 0, 0);
    step(1, 16'hbb01, 16'h0021, 0, 0);
    step(1, 16'hbb02, 16'h0022, 0, 0);
    step(1, 16'hbeef, 16'h0023, 1, 1);
    step(0, 16'h0000, 16'h0000, 0, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 16'h0100 + 16'(i), 16'(i + 1), 1, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(1, 16'hcc01, 16'h0031, 0, 0);
    step(1, 16'hcc02, 16'h0032, 0, 0);
    q.in_valid = 0;
    chk("pre_async_count", 32'(q.count), 2);
    #2;
    rst = 0;
    #1;
    chk("async_out_valid", 32'(q.out_valid), 0);
    chk("async_count", 32'(q.count), 0);
    chk("async_in_ready", 32'(q.in_ready), 1);
    chk("async_out_instr", 32'(q.out_instr), 0);
    mcnt = 0;
    exp_q.delete();
    #3;
    rst = 1;
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(1, 16'hdd01, 16'h0041, 1, 0);
    step(0, 16'h0000, 16'h0000, 1, 0);
    step(0, 16'h0000, 16'h0000, 0, 0);
    chk("drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
